// File: rtl/bitonic_pkg.sv
// Shared constants, state encoding and pair-selection helpers for the bitonic sorter.
package bitonic_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned NPASS = 6;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned NCAS  = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Bitonic network schedule: block size k and partner distance j per pass.
  localparam int unsigned PASS_K [NPASS] = '{2, 4, 4, 8, 8, 8};
  localparam int unsigned PASS_J [NPASS] = '{1, 2, 1, 4, 2, 1};

  // Block size for a pass; unused pass codes fall back to the final merge.
  function automatic logic [3:0] pass_k(input logic [2:0] pass);
    pass_k = 4'd8;
    for (int unsigned p = 0; p < NPASS; p++) begin
      if (3'(p) == pass) pass_k = 4'(PASS_K[p]);
    end
  endfunction

  // Partner distance for a pass; unused pass codes fall back to distance 1.
  function automatic logic [2:0] pass_j(input logic [2:0] pass);
    pass_j = 3'd1;
    for (int unsigned p = 0; p < NPASS; p++) begin
      if (3'(p) == pass) pass_j = 3'(PASS_J[p]);
    end
  endfunction

  // Lower index of the q-th pair: q with a zero inserted at the bit set in j.
  function automatic logic [2:0] pair_lo(input logic [1:0] q, input logic [2:0] j);
    case (j)
      3'd1:    pair_lo = {q, 1'b0};
      3'd2:    pair_lo = {q[1], 1'b0, q[0]};
      default: pair_lo = {1'b0, q};
    endcase
  endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Compare-exchange cell: orders (a, b) into (lo, hi); equal values pass straight through.
module bitonic_cas #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         asc,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap_c;

  // Swap only on a strict ordering violation so ties never move.
  always_comb begin
    swap_c = asc ? (a > b) : (a < b);
    lo     = swap_c ? b : a;
    hi     = swap_c ? a : b;
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// 8-entry sequential bitonic sorter: serial load, six compare-exchange passes, serial drain.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter bit          DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pass_q, pass_d;
  logic [W-1:0]       buf_q [N];
  logic [W-1:0]       buf_d [N];
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   lo_idx [NCAS];
  logic [IDX_W-1:0]   hi_idx [NCAS];
  logic               asc    [NCAS];
  logic [W-1:0]       cas_a  [NCAS];
  logic [W-1:0]       cas_b  [NCAS];
  logic [W-1:0]       cas_lo [NCAS];
  logic [W-1:0]       cas_hi [NCAS];
  logic [2:0]         j_c;
  logic [3:0]         k_c;
  logic [IDX_W-1:0]   out_idx_c;

  // Pick the four index pairs and their direction for the current pass.
  always_comb begin
    j_c = pass_j(pass_q);
    k_c = pass_k(pass_q);
    for (int q = 0; q < int'(NCAS); q++) begin
      lo_idx[q] = pair_lo(2'(q), j_c);
      hi_idx[q] = lo_idx[q] ^ j_c;
      asc[q]    = (({1'b0, lo_idx[q]} & k_c) == 4'd0);
      cas_a[q]  = buf_q[lo_idx[q]];
      cas_b[q]  = buf_q[hi_idx[q]];
    end
  end

  for (genvar g = 0; g < int'(NCAS); g++) begin : g_cas
    bitonic_cas #(.W(W)) u_cas (
      .a   (cas_a[g]),
      .b   (cas_b[g]),
      .asc (asc[g]),
      .lo  (cas_lo[g]),
      .hi  (cas_hi[g])
    );
  end

  // Next-state, buffer update and registered handshake flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    for (int i = 0; i < int'(N); i++) buf_d[i] = buf_q[i];

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          buf_d[cnt_q] = in_data;
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            pass_d  = 3'd0;
            state_d = SORT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      SORT: begin
        for (int q = 0; q < int'(NCAS); q++) begin
          buf_d[lo_idx[q]] = cas_lo[q];
          buf_d[hi_idx[q]] = cas_hi[q];
        end
        if (pass_q == 3'(NPASS - 1)) begin
          pass_d  = 3'd0;
          cnt_d   = 3'd0;
          state_d = OUT;
        end else begin
          pass_d = pass_q + 3'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != LOAD);
  end

  // State and buffer registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      pass_q      <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < int'(N); i++) buf_q[i] <= buf_d[i];
    end
  end

  // Output element selected from the sorted buffer; zero outside the drain phase.
  always_comb begin
    out_idx_c = DESCEND ? (3'd7 - cnt_q) : cnt_q;
    out_data  = out_valid_q ? buf_q[out_idx_c] : '0;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Self-checking bench for bitonic_sort_ctrl: directed frames plus random frames vs a sort model.
module tb_bitonic_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       sel;

  logic       a_ir, a_ov, a_busy, b_ir, b_ov, b_busy;
  logic [7:0] a_od, b_od;
  logic       ir, ov, busy;
  logic [7:0] od;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bitonic_sort_ctrl #(.W(8), .DESCEND(1'b0)) dut_asc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(out_ready & ~sel),
    .busy(a_busy)
  );

  bitonic_sort_ctrl #(.W(8), .DESCEND(1'b1)) dut_desc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_data(in_data), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(out_ready & sel),
    .busy(b_busy)
  );

  assign ir   = sel ? b_ir   : a_ir;
  assign ov   = sel ? b_ov   : a_ov;
  assign od   = sel ? b_od   : a_od;
  assign busy = sel ? b_busy : a_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain sort of the frame, reversed for largest-first output.
  function automatic void model_sort(input logic [7:0] v [8], input bit desc, output logic [7:0] r [8]);
    int a [8];
    int t;
    for (int i = 0; i < 8; i++) a[i] = int'(v[i]);
    for (int i = 0; i < 8; i++)
      for (int m = 0; m < 7 - i; m++)
        if (a[m] > a[m+1]) begin t = a[m]; a[m] = a[m+1]; a[m+1] = t; end
    for (int i = 0; i < 8; i++) r[i] = desc ? 8'(a[7-i]) : 8'(a[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 back-to-back, 1 random gaps. stall_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
  task automatic run_frame(input logic [7:0] v [8], input bit desc, input int gap_mode,
                           input int stall_mode, input bit junk);
    logic [7:0] exp [8];
    int cyc, t, waitc;
    bit rdy;
    model_sort(v, desc, exp);
    sel = desc;
    for (int n = 0; n < 8; n++) begin
      if (gap_mode != 0) begin
        repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; tick(); end
      end
      in_valid = 1'b1;
      in_data  = v[n];
      check("in_ready_load", 32'(ir), 32'd1);
      tick();
    end
    in_valid = junk;
    in_data  = 8'h11;
    cyc = 0;
    while (!ov && cyc < 20) begin
      check("in_ready_sort", 32'(ir), 32'd0);
      check("busy_sort", 32'(busy), 32'd1);
      tick();
      cyc++;
    end
    check("latency_from_last_input", 32'(cyc + 1), 32'd7);
    t = 0;
    for (int m = 0; m < 8; m++) begin
      waitc = 0;
      rdy   = 1'b0;
      while (!rdy && waitc < 20) begin
        check("out_valid", 32'(ov), 32'd1);
        check("out_data", 32'(od), 32'(exp[m]));
        check("in_ready_out", 32'(ir), 32'd0);
        case (stall_mode)
          0:       rdy = 1'b1;
          1:       rdy = (t % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        out_ready = rdy;
        tick();
        t++;
        waitc++;
      end
      if (!rdy) check("out_accept_timeout", 32'(waitc), 32'd0);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_after_frame", 32'(ov), 32'd0);
    check("in_ready_after_frame", 32'(ir), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] f [8];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    sel       = 1'b0;
    #12;
    check("rst_out_valid", 32'(a_ov), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_out_data", 32'(a_od), 32'd0);
    check("rst_desc_out_valid", 32'(b_ov), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", 32'(a_ir), 32'd1);

    f = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
    run_frame(f, 1'b0, 0, 0, 1'b0);

    f = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248};
    run_frame(f, 1'b0, 1, 1, 1'b0);

    f = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    run_frame(f, 1'b0, 0, 0, 1'b0);
    f = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
    run_frame(f, 1'b0, 0, 0, 1'b0);

    f = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50};
    run_frame(f, 1'b0, 0, 1, 1'b1);

    // Abort a frame in SORT pass 3, then sort a fresh frame.
    f = '{8'd200, 8'd100, 8'd150, 8'd50, 8'd25, 8'd75, 8'd175, 8'd125};
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = f[n];
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("busy_before_abort", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(a_ov), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_in_ready", 32'(a_ir), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("no_residual_output", 32'(a_ov), 32'd0);
      tick();
    end
    f = '{8'd9, 8'd9, 8'd1, 8'd1, 8'd5, 8'd5, 8'd3, 8'd3};
    run_frame(f, 1'b0, 0, 0, 1'b0);

    f = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
    run_frame(f, 1'b1, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 8; n++) f[n] = 8'($urandom_range(0, (r < 3) ? 7 : 255));
      run_frame(f, 1'(r % 2), 1, 2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
